// File: rtl/md_unit_param_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             hl_write;
  logic             hl_sel;
  logic             interrupt_request;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, d1, d2, hl_write, hl_sel, interrupt_request,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, d1, d2, hl_write, hl_sel, interrupt_request,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide/accumulate unit with HI/LO registers and abortable operations.
// state   | meaning
// IDLE    | accepts start or HI/LO writes
// RUN     | op in flight, busy high, counter walks N..1
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic            clk,
  input logic            reset,
  md_unit_param_if.slave md
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0]    MUL_N   = CW'(MUL_CYCLES);
  localparam logic [CW-1:0]    DIV_N   = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic                      is_div_in;
  logic                      div0;
  logic                      launch;
  logic [2*WIDTH-1:0]        prod_u;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod;
  logic [2*WIDTH-1:0]        acc;
  logic [WIDTH-1:0]          q_u, r_u;
  logic signed [WIDTH-1:0]   sa, sb, q_s, r_s;
  logic [2*WIDTH-1:0]        result;

  always_comb begin
    is_div_in = (md.op == 3'd2) || (md.op == 3'd3);
    div0      = md.start && is_div_in && (md.d2 == '0);
    launch    = (state_q == ST_IDLE) && md.start && !md.interrupt_request && !div0;
  end

  // HI/LO cannot change while RUN, so the live registers serve as the accumulator
  // captured at launch.
  always_comb begin
    acc    = {hi_q, lo_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod   = op_q[0] ? prod_s : prod_u;

    q_u = a_q / b_q;
    r_u = a_q % b_q;

    sa  = $signed(a_q);
    sb  = $signed(b_q);
    q_s = sa / sb;
    r_s = sa % sb;
    // The one signed overflow case wraps instead of trapping.
    if ((a_q == INT_MIN) && (b_q == '1)) begin
      q_s = sa;
      r_s = '0;
    end

    result = prod;
    case (op_q)
      3'd0, 3'd1: result = prod;
      3'd2:       result = {r_u, q_u};
      3'd3:       result = {r_s, q_s};
      3'd4, 3'd5: result = acc + prod;
      3'd6, 3'd7: result = acc - prod;
      default:    result = prod;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_RUN;
          cnt_d   = is_div_in ? DIV_N : MUL_N;
          op_d    = md.op;
          a_d     = md.d1;
          b_d     = md.d2;
        end else if (md.hl_write && !md.start && !md.interrupt_request) begin
          if (md.hl_sel) hi_d = md.d1;
          else           lo_d = md.d1;
        end
      end
      ST_RUN: begin
        if (md.interrupt_request) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign md.busy = (state_q == ST_RUN);
  assign md.done = done_q;
  assign md.div0 = div0;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit_param.sv
// Directed plus randomized checks of md_unit_param against an arithmetic reference model.
module tb_md_unit_param;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit [31:0] m_hi, m_lo;

  md_unit_param_if #(.WIDTH(32)) md();

  md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic bit [63:0] ref_md(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                       input bit [31:0] hi, input bit [31:0] lo);
    bit [63:0] acc;
    bit [63:0] p;
    bit [31:0] uq;
    longint    sa, sb, q, r;
    acc = {hi, lo};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (op[0]) p = sa * sb;
    else       p = {32'h0, a} * {32'h0, b};
    case (op)
      3'd0, 3'd1: return p;
      3'd4, 3'd5: return acc + p;
      3'd6, 3'd7: return acc - p;
      3'd2: begin
        uq = a / b;
        return {a - uq * b, uq};
      end
      3'd3: begin
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle_inputs();
    md.start             = 1'b0;
    md.op                = 3'd0;
    md.d1                = '0;
    md.d2                = '0;
    md.hl_write          = 1'b0;
    md.hl_sel            = 1'b0;
    md.interrupt_request = 1'b0;
  endtask

  task automatic mt(input bit sel, input bit [31:0] val);
    md.hl_write = 1'b1;
    md.hl_sel   = sel;
    md.d1       = val;
    cyc();
    md.hl_write = 1'b0;
    if (sel) m_hi = val;
    else     m_lo = val;
    chkw("mt_hi", md.hi, m_hi);
    chkw("mt_lo", md.lo, m_lo);
  endtask

  task automatic run_op(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                        input int abort_at, input bit junk);
    bit [63:0] exp;
    int        n;
    bit        is_div;
    bit        zero;
    is_div = (op == 3'd2) || (op == 3'd3);
    n      = is_div ? 10 : 5;
    zero   = is_div && (b == 32'h0);
    exp    = ref_md(op, a, b, m_hi, m_lo);
    md.start = 1'b1;
    md.op    = op;
    md.d1    = a;
    md.d2    = b;
    #1;
    chkb("div0", md.div0, zero);
    cyc();
    md.start = 1'b0;
    md.d1    = $urandom;
    md.d2    = $urandom | 32'h1;
    if (zero) begin
      chkb("div0_busy", md.busy, 1'b0);
      chkw("div0_hi", md.hi, m_hi);
      chkw("div0_lo", md.lo, m_lo);
      return;
    end
    for (int i = 1; i <= n; i++) begin
      chkb("busy_high", md.busy, 1'b1);
      chkb("done_low", md.done, 1'b0);
      if (junk && i == 2) begin
        md.start    = 1'b1;
        md.op       = 3'd3;
        md.hl_write = 1'b1;
        md.hl_sel   = 1'b1;
      end
      if (abort_at == i) md.interrupt_request = 1'b1;
      cyc();
      md.start             = 1'b0;
      md.hl_write          = 1'b0;
      md.interrupt_request = 1'b0;
      if (abort_at == i) begin
        chkb("abort_busy", md.busy, 1'b0);
        chkb("abort_done", md.done, 1'b0);
        chkw("abort_hi", md.hi, m_hi);
        chkw("abort_lo", md.lo, m_lo);
        return;
      end
    end
    chkb("end_busy", md.busy, 1'b0);
    chkb("done_pulse", md.done, 1'b1);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chkw("res_hi", md.hi, m_hi);
    chkw("res_lo", md.lo, m_lo);
    cyc();
    chkb("done_clear", md.done, 1'b0);
  endtask

  initial begin
    int  n_r;
    bit [2:0]  rop;
    bit [31:0] ra, rb;
    checks   = 0;
    failures = 0;
    m_hi     = '0;
    m_lo     = '0;
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chkb("rst_busy", md.busy, 1'b0);
    chkb("rst_done", md.done, 1'b0);
    chkw("rst_hi", md.hi, 32'h0);
    chkw("rst_lo", md.lo, 32'h0);

    run_op(3'd1, 32'hFFFFFFFD, 32'd7, 0, 1'b0);
    chkw("mult_hi_const", md.hi, 32'hFFFFFFFF);
    chkw("mult_lo_const", md.lo, 32'hFFFFFFEB);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    chkw("div_lo_const", md.lo, 32'hFFFFFFFD);
    chkw("div_hi_const", md.hi, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    chkw("divu_lo_const", md.lo, 32'h7FFFFFFC);
    chkw("divu_hi_const", md.hi, 32'h00000001);

    mt(1'b0, 32'hFFFFFFFF);
    mt(1'b1, 32'h0);
    run_op(3'd4, 32'd1, 32'd1, 0, 1'b0);
    chkw("maddu_hi_const", md.hi, 32'h1);
    chkw("maddu_lo_const", md.lo, 32'h0);
    run_op(3'd7, 32'd1, 32'd1, 0, 1'b0);
    chkw("msub_hi_const", md.hi, 32'h0);
    chkw("msub_lo_const", md.lo, 32'hFFFFFFFF);

    run_op(3'd3, 32'd1234, 32'h0, 0, 1'b0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    chkw("ovf_lo_const", md.lo, 32'h80000000);
    chkw("ovf_hi_const", md.hi, 32'h0);

    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 3, 1'b0);
    run_op(3'd1, 32'h00010003, 32'hFFFF0005, 0, 1'b1);

    // Reset in the second busy cycle discards the op and clears HI/LO.
    md.start = 1'b1;
    md.op    = 3'd1;
    md.d1    = 32'h55;
    md.d2    = 32'h77;
    cyc();
    md.start = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    chkb("midrst_busy", md.busy, 1'b0);
    chkb("midrst_done", md.done, 1'b0);
    chkw("midrst_hi", md.hi, 32'h0);
    chkw("midrst_lo", md.lo, 32'h0);

    // Interrupt in IDLE blocks launch and HI/LO writes; start beats hl_write.
    md.start = 1'b1;
    md.op    = 3'd0;
    md.d1    = 32'd3;
    md.d2    = 32'd5;
    md.interrupt_request = 1'b1;
    cyc();
    md.start = 1'b0;
    chkb("irq_idle_busy", md.busy, 1'b0);
    md.hl_write = 1'b1;
    md.hl_sel   = 1'b0;
    md.d1       = 32'hCAFE;
    cyc();
    md.interrupt_request = 1'b0;
    chkw("irq_idle_lo", md.lo, m_lo);
    md.start = 1'b1;
    md.op    = 3'd3;
    md.d2    = 32'h0;
    #1;
    chkb("div0_hlw", md.div0, 1'b1);
    cyc();
    idle_inputs();
    chkb("start_wins_busy", md.busy, 1'b0);
    chkw("start_wins_lo", md.lo, m_lo);

    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h80000000;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      n_r = ((rop == 3'd2) || (rop == 3'd3)) ? 10 : 5;
      run_op(rop, ra, rb, ($urandom_range(0, 4) == 0) ? $urandom_range(1, n_r) : 0,
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
- Successor to the fixed 32-bit MD block; adds configurable width and latencies, plus MADD/MADDU/MSUB/MSUBU accumulate ops.
- Adds a done pulse and interrupt abort with no partial HI/LO commit.
- Sits beside the ALU; busy stalls decode; HI/LO feed the ALU-output mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for mul/madd/msub ops (>=1).
- DIV_CYCLES, 10, busy cycles for div ops (>=1).

Ports:
- clk  input  1  clock; single clock domain, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation op this cycle.
- op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB.
- d1  input  WIDTH  operand A / dividend / MTHI-MTLO data.
- d2  input  WIDTH  operand B / divisor.
- hl_write  input  1  write d1 into HI or LO.
- hl_sel  input  1  0 = LO, 1 = HI.
- interrupt_request  input  1  abort in-flight op, block new launches.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on HI/LO commit.
- div0  output  1  combinational: start & op in {2,3} & d2 == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (wins over all inputs): hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset mid-op discards the op.
- States:
  - IDLE -> RUN when start & !interrupt_request & !div0.
  - RUN -> IDLE after N cycles, or on interrupt_request.
- Launch:
  - Operands, op, and the current hi/lo (for accumulate ops) are latched at the start edge.
  - busy=1 from the next cycle for exactly N cycles; N = MUL_CYCLES (op 0,1,4-7) or DIV_CYCLES (op 2,3).
  - On the edge ending the last busy cycle: hi/lo updated, busy->0, done=1 for one cycle.
  - Results are readable the cycle after busy falls.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
  - MADD(U)/MSUB(U): {hi,lo} = latched {hi,lo} +/- product, modulo 2^(2*WIDTH).
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - DIV of -2^(WIDTH-1) / -1: lo = -2^(WIDTH-1), hi = 0; no trap.
- div0: start of op 2/3 with d2 == 0 raises div0 that cycle; no launch, busy stays 0, hi/lo unchanged.
- hl_write:
  - Honoured only in IDLE with no start that cycle; writes d1 at the next edge.
  - Ignored while busy; start wins if both are asserted.
- start while busy: ignored; in-flight op unaffected.
- interrupt_request:
  - In RUN: next edge returns to IDLE, busy=0, no done, hi/lo keep pre-launch values.
  - In IDLE: blocks start and hl_write that cycle.
- Internal counter width clog2(max(MUL_CYCLES,DIV_CYCLES))+1; no wrap beyond N.

Test Plan (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10):
- MULT d1=0xFFFFFFFD, d2=7 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one pulse.
- DIV d1=0xFFFFFFF9 (-7), d2=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU d1=1, d2=1 -> hi=1, lo=0; MSUB d1=1, d2=1 -> hi=0, lo=0xFFFFFFFF.
- DIV d2=0 -> div0=1 that cycle, busy stays 0, hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT launched, interrupt_request in busy cycle 3 -> busy 0 next cycle, no done, hi/lo = pre-launch values.
- MULT launched, then start DIV and hl_write during busy -> both ignored, MULT result correct.
- MULT launched, reset during busy cycle 2 -> hi=lo=0, busy=0.
